pll_lock_seq: RTL
=================

# pll_lock_seq

Power-up and recovery sequencer for the board clocking PLL (`clk_wiz_0` instance). It pulses the PLL reset, waits for `locked` with a timeout, qualifies lock over a stability window, then releases the downstream system reset. Lock loss returns the block to the reset sequence, and repeated acquisition failures latch a fault. It runs on the free-running reference clock that feeds the PLL, upstream of all logic clocked by the PLL output.

## Interface
Parameters:
- `RST_CYCLES`, 16: width of the PLL reset pulse, in cycles (≥2).
- `LOCK_TIMEOUT`, 65536: maximum cycles in WAIT_LOCK per attempt.
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before RUN.
- `MAX_RETRIES`, 3: failed attempts allowed before FAULT (≥1).

Ports:
- `clk_in1` in 1: free-running reference clock, the same net as the PLL input.
- `resetn` in 1: reset, asynchronous, active-low.
- `pll_locked` in 1: PLL `locked`. Asynchronous to `clk_in1`.
- `restart` in 1: single-cycle request to re-run the full sequence.
- `pll_reset` out 1: active-high reset to the PLL.
- `sys_rst_n` out 1: active-low reset for the PLL-clocked domain.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `lock_lost` out 1: one-cycle pulse when lock drops while in RUN.
- `retry_cnt` out `$clog2(MAX_RETRIES+1)`: number of failed attempts in the current acquisition.
- `state` out 3: current state encoding, for debug.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. All decisions use `locked_s` only.
- States and encodings: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4.
- **RESET_PLL**
  - `pll_reset`=1 for exactly RST_CYCLES cycles, counted by `cnt`.
  - Then go to WAIT_LOCK with `cnt` cleared.
- **WAIT_LOCK**
  - `locked_s`=1 → STABILIZE with `cnt` cleared.
  - Otherwise, when `cnt`=LOCK_TIMEOUT-1 the attempt fails.
- **STABILIZE**
  - `locked_s`=0 → the attempt fails.
  - `cnt` reaching STABLE_CYCLES-1 with `locked_s`=1 → RUN.
- **Failed attempt:** `retry_cnt`++. If the new value equals MAX_RETRIES → FAULT, otherwise → RESET_PLL.
- **RUN**
  - `sys_rst_n`=1 and `ready`=1.
  - Entry clears `retry_cnt`.
  - `locked_s`=0 → pulse `lock_lost`, deassert `sys_rst_n`, go to RESET_PLL.
- **FAULT**
  - Terminal: `pll_reset`=1, `sys_rst_n`=0.
  - Left only by `restart` or `resetn`.
- **`restart`**
  - In any state: go to RESET_PLL and clear `retry_cnt` and `cnt`.
  - Has priority over every other transition in the same cycle, including a simultaneous lock loss in RUN. In that case `lock_lost` still pulses.
- `sys_rst_n` is 0 in every state except RUN.
- `pll_reset` is 1 in RESET_PLL and FAULT, 0 otherwise.
- `cnt` is wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES). It saturates and never wraps.

## Timing
- All outputs are registered and reflect the state of the same cycle (Moore). `lock_lost` is registered alongside the transition.
- Reset values:
  - `state`=RESET_PLL, `pll_reset`=1, `sys_rst_n`=0.
  - `ready`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0, `cnt`=0, synchronizer flops=0.
- Reset asserted mid-operation forces the values above immediately (asynchronously). After release, the first edge begins counting RST_CYCLES.
- Latency from `pll_locked` rising to `sys_rst_n` rising:
  - 2 cycles for the synchronizer
  - +1 cycle for the WAIT_LOCK→STABILIZE transition
  - +STABLE_CYCLES cycles in STABILIZE.
- Lock loss in RUN to `sys_rst_n`=0: 3 cycles after the `pll_locked` fall (2 synchronizer + 1 register).
- A glitch on `pll_locked` shorter than one cycle may be missed. This is acceptable.

## Structure
- Package `pll_ctrl_pkg` holds:
  - the state typedef and encodings
  - a `CNT_W` function computing the counter width.
- Sub-module `sync_2ff`: single-bit 2-flop synchronizer with asynchronous active-low reset to 0. It is reusable elsewhere in the codebase.
- No other hierarchy.

## Test plan
Benches use small parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3.
- **Normal bring-up.** Release `resetn`, raise `pll_locked` at cycle 10 → `pll_reset` is 1 for cycles 0–3, then 0. `sys_rst_n` and `ready` rise exactly 11 cycles after the `pll_locked` edge.
- **Timeout to fault.** Hold `pll_locked`=0 → `retry_cnt` steps 1, 2, 3 with a 4-cycle `pll_reset` pulse between attempts. `fault`=1, `pll_reset`=1 and `state`=4 latch after the third 20-cycle timeout.
- **Unstable lock.** Drop `pll_locked` after 5 cycles in STABILIZE → `retry_cnt`=1 and the block returns to RESET_PLL. A second, clean lock reaches RUN and clears `retry_cnt` to 0.
- **Lock loss in RUN.** Drop `pll_locked` → `lock_lost` pulses once, and `sys_rst_n`=0 within 3 cycles of the fall. The full sequence reruns.
- **Restart priority.** Assert `restart` in FAULT → RESET_PLL with `retry_cnt`=0. Assert `restart` in RUN in the same cycle that `locked_s` falls → next state is RESET_PLL and `lock_lost` pulses.
- **Reset mid-operation.** Assert `resetn` low in STABILIZE → all outputs take their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | pll_ctrl_pkg : shared types and helpers for PLL lock sequencing    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // Counter width covering the largest interval, with room to hold the saturation value.
  function automatic int CNT_W(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m + 1);
  endfunction

  // Output pattern {pll_reset, sys_rst_n, ready, fault} held while in each state.
  function automatic logic [3:0] state_outs(input pll_state_t s);
    case (s)
      RESET_PLL: return 4'b1000;
      WAIT_LOCK: return 4'b0000;
      STABILIZE: return 4'b0000;
      RUN:       return 4'b0110;
      FAULT:     return 4'b1001;
      default:   return 4'b1000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +--------------------------------------------------------------------+
// | sync_2ff : single-bit two-flop synchronizer, async active-low reset|
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pll_lock_seq.sv
// +--------------------------------------------------------------------+
// | pll_lock_seq : PLL reset / lock-qualify / system-reset sequencer   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pll_lock_seq
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                               clk_in1,
  input  logic                               resetn,
  input  logic                               pll_locked,
  input  logic                               restart,
  output logic                               pll_reset,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state
);

  localparam int CW = CNT_W(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

  pll_state_t       st;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [RW-1:0]    retry_inc;
  logic             locked_s;

  sync_2ff u_lock_sync (
    .clk   (clk_in1),
    .rst_n (resetn),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign cnt_inc   = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  assign retry_inc = retry_cnt + 1'b1;
  assign state     = st;

  // Every state change restarts the interval counter and loads that state's outputs.
  task automatic enter(input pll_state_t s);
    st  <= s;
    cnt <= '0;
    {pll_reset, sys_rst_n, ready, fault} <= state_outs(s);
  endtask

  task automatic fail_attempt();
    retry_cnt <= retry_inc;
    if (retry_inc == RETRY_LIMIT) enter(FAULT);
    else                          enter(RESET_PLL);
  endtask

  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      st        <= RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (restart) begin
        // Restart wins, but a lock drop seen in the same cycle is still reported.
        if (st == RUN && !locked_s) lock_lost <= 1'b1;
        retry_cnt <= '0;
        enter(RESET_PLL);
      end else begin
        case (st)
          RESET_PLL: begin
            if (cnt == RST_LAST) enter(WAIT_LOCK);
            else                 cnt <= cnt_inc;
          end
          WAIT_LOCK: begin
            if (locked_s)            enter(STABILIZE);
            else if (cnt == TO_LAST) fail_attempt();
            else                     cnt <= cnt_inc;
          end
          STABILIZE: begin
            if (!locked_s) begin
              fail_attempt();
            end else if (cnt == STABLE_LAST) begin
              retry_cnt <= '0;
              enter(RUN);
            end else begin
              cnt <= cnt_inc;
            end
          end
          RUN: begin
            if (!locked_s) begin
              lock_lost <= 1'b1;
              enter(RESET_PLL);
            end
          end
          FAULT: begin
          end
          default: enter(RESET_PLL);
        endcase
      end
    end
  end

endmodule

`default_nettype wire
